// File: rtl/uart_tx_dev_if.sv
// Bridge-side device bus for the serial transmitter: byte address, write strobe, write and read data.
interface uart_tx_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter: CTRL/DIV/TXDATA/STATUS registers, frame FSM, sticky DONE/OVR and IRQ.
module uart_tx_dev #(
  parameter int unsigned      DATA_BITS = 8,
  parameter int unsigned      DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RST   = 16'd16
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_dev_if.slave    bus,
  output logic            IRQ,
  output logic            tx_line
);

  localparam int unsigned      BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nx;
  logic [DIV_W-1:0]       div_q, period, period_nx, cnt, cnt_nx;
  logic [BIT_W-1:0]       bit_idx, bit_nx;
  logic [DATA_BITS-1:0]   shift, shift_nx, txdata;
  logic                   en, im, done, ovr, tx_q, tx_nx;
  logic                   busy, last_cyc, stop_last, tx_free, accept, frame_end;
  logic                   wr_ctrl, wr_div, wr_tx, wr_stat;

  assign wr_ctrl = bus.WE && (bus.Addr[3:2] == 2'd0);
  assign wr_div  = bus.WE && (bus.Addr[3:2] == 2'd1);
  assign wr_tx   = bus.WE && (bus.Addr[3:2] == 2'd2);
  assign wr_stat = bus.WE && (bus.Addr[3:2] == 2'd3);

  assign busy      = (state != IDLE);
  assign last_cyc  = (cnt == period - ONE);
  assign stop_last = (state == STOP) && last_cyc;
  // The final stop-bit cycle counts as free so a store landing on the edge BUSY drops chains a new frame.
  assign tx_free   = (state == IDLE) || stop_last;
  assign accept    = wr_tx && en && tx_free;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bit_nx    = bit_idx;
    shift_nx  = shift;
    period_nx = period;
    frame_end = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        if (last_cyc) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      DATA: begin
        if (last_cyc) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          if (bit_idx == LAST) state_nx = STOP;
          else                 bit_nx   = bit_idx + BIT_W'(1);
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      STOP: begin
        if (last_cyc) begin
          cnt_nx    = '0;
          frame_end = 1'b1;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      state_nx  = START;
      cnt_nx    = '0;
      bit_nx    = '0;
      shift_nx  = bus.Din[DATA_BITS-1:0];
      period_nx = (div_q == '0) ? ONE : div_q;
    end
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      period  <= ONE;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
      period  <= period_nx;
      tx_q    <= tx_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      im     <= 1'b0;
      div_q  <= DIV_RST;
      txdata <= '0;
      done   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (wr_ctrl) {im, en} <= bus.Din[1:0];
      if (wr_div)  div_q    <= bus.Din[DIV_W-1:0];
      if (wr_tx && tx_free) txdata <= bus.Din[DATA_BITS-1:0];
      // Set beats a simultaneous write-1 clear on both sticky flags.
      if (frame_end)                   done <= 1'b1;
      else if (wr_stat && bus.Din[1])  done <= 1'b0;
      if (wr_tx && !tx_free)           ovr  <= 1'b1;
      else if (wr_stat && bus.Din[2])  ovr  <= 1'b0;
    end
  end

  always_comb begin
    case (bus.Addr[3:2])
      2'd0:    bus.Dout = {30'b0, im, en};
      2'd1:    bus.Dout = 32'(div_q);
      2'd2:    bus.Dout = 32'(txdata);
      default: bus.Dout = {29'b0, ovr, done, busy};
    endcase
  end

  assign IRQ     = done & im;
  assign tx_line = tx_q;

  logic unused_bits;
  assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din};

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register access, 8N1 frame timing, flags, overrun and back-to-back frames.
module tb_uart_tx_dev;

  logic clk = 1'b0;
  logic reset;
  logic irq, tx_line;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  uart_tx_dev_if bus ();

  uart_tx_dev #(.DATA_BITS(8), .DIV_W(16), .DIV_RST(16'd16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .IRQ     (irq),
    .tx_line (tx_line)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.Dout;
  endtask

  // Expected line level for bit slot k of a frame carrying byte b (0 start, 1..8 data, 9 stop).
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    logic [7:0] v;
    v = b;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return v[k-1];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    wr(32'h0, 32'h1);
    wr(32'h8, 32'h0);
    repeat (5) tick();
    total_cnt++;
    if (tx_line !== 1'b0) $display("FAIL reset_prelude_start tx=%b want 0", tx_line); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (tx_line !== 1'b1) $display("FAIL reset_tx tx=%b want 1", tx_line); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq irq=%b want 0", irq); else pass_cnt++;
    rd(32'h4, d);
    total_cnt++;
    if (d !== 32'd16) $display("FAIL reset_div got %h want 00000010", d); else pass_cnt++;
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL reset_status got %h want 00000000", d); else pass_cnt++;
    rd(32'h0, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL reset_ctrl got %h want 00000000", d); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_frame_a5();
    logic [31:0] d;
    wr(32'h4, 32'd4);
    wr(32'h0, 32'd3);
    wr(32'h8, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'hA5, i / 4))
        $display("FAIL a5_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'hA5, i / 4));
      else pass_cnt++;
      rd(32'hC, d);
      total_cnt++;
      if (d[0] !== 1'b1) $display("FAIL a5_busy cycle %0d busy=%b want 1", i, d[0]); else pass_cnt++;
      tick();
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL a5_status_end got %h want 00000002", d); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL a5_irq irq=%b want 1", irq); else pass_cnt++;
    total_cnt++;
    if (tx_line !== 1'b1) $display("FAIL a5_idle_tx tx=%b want 1", tx_line); else pass_cnt++;
  endtask

  task automatic test_done_clear();
    logic [31:0] d;
    wr(32'hC, 32'h2);
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL clr_status got %h want 00000000", d); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL clr_irq irq=%b want 0", irq); else pass_cnt++;
    wr(32'h0, 32'h1);
    wr(32'h4, 32'h1);
    wr(32'h8, 32'h81);
    repeat (10) tick();
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL masked_status got %h want 00000002", d); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL masked_irq irq=%b want 0", irq); else pass_cnt++;
    wr(32'hC, 32'h0);
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL write0_noeffect got %h want 00000002", d); else pass_cnt++;
    wr(32'h0, 32'h3);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL unmask_irq irq=%b want 1", irq); else pass_cnt++;
    wr(32'h0, 32'h1);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL remask_irq irq=%b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_en_off();
    logic [31:0] d;
    wr(32'hC, 32'h6);
    wr(32'h0, 32'h0);
    wr(32'h8, 32'h77);
    rd(32'h8, d);
    total_cnt++;
    if (d !== 32'h77) $display("FAIL enoff_txdata got %h want 00000077", d); else pass_cnt++;
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL enoff_status got %h want 00000000", d); else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (tx_line !== 1'b1) $display("FAIL enoff_tx tx=%b want 1", tx_line); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    wr(32'h0, 32'h3);
    wr(32'h4, 32'h2);
    wr(32'h8, 32'h55);
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'h55, i / 2))
        $display("FAIL ovr_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'h55, i / 2));
      else pass_cnt++;
      if (i == 3) begin
        bus.Addr = 32'h8;
        bus.Din  = 32'hFF;
        bus.WE   = 1'b1;
      end
      tick();
      bus.WE = 1'b0;
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h6) $display("FAIL ovr_status got %h want 00000006", d); else pass_cnt++;
    rd(32'h8, d);
    total_cnt++;
    if (d !== 32'h55) $display("FAIL ovr_txdata got %h want 00000055", d); else pass_cnt++;
  endtask

  task automatic test_div0();
    logic [31:0] d;
    wr(32'hC, 32'h6);
    wr(32'h4, 32'h0);
    wr(32'h8, 32'h01);
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'h01, i))
        $display("FAIL div0_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'h01, i));
      else pass_cnt++;
      if (i == 2) begin
        bus.Addr = 32'h4;
        bus.Din  = 32'h8;
        bus.WE   = 1'b1;
      end
      tick();
      bus.WE = 1'b0;
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL div0_status got %h want 00000002", d); else pass_cnt++;
    rd(32'h4, d);
    total_cnt++;
    if (d !== 32'h8) $display("FAIL div0_divreg got %h want 00000008", d); else pass_cnt++;
    total_cnt++;
    if (tx_line !== 1'b1) $display("FAIL div0_idle_tx tx=%b want 1", tx_line); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(32'hC, 32'h6);
    wr(32'h4, 32'h2);
    wr(32'h8, 32'h0F);
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'h0F, i / 2))
        $display("FAIL b2b_a_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'h0F, i / 2));
      else pass_cnt++;
      if (i == 19) begin
        bus.Addr = 32'hC;
        bus.Din  = 32'h2;
        bus.WE   = 1'b1;
      end
      tick();
      bus.WE = 1'b0;
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL setwins_status got %h want 00000002", d); else pass_cnt++;
    wr(32'h8, 32'h3C);
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'h3C, i / 2))
        $display("FAIL b2b_b_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'h3C, i / 2));
      else pass_cnt++;
      if (i == 19) begin
        bus.Addr = 32'h8;
        bus.Din  = 32'hC3;
        bus.WE   = 1'b1;
      end
      tick();
      bus.WE = 1'b0;
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL chain_status got %h want 00000003", d); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (tx_line !== exp_tx(8'hC3, i / 2))
        $display("FAIL b2b_c_tx cycle %0d tx=%b want %b", i, tx_line, exp_tx(8'hC3, i / 2));
      else pass_cnt++;
      tick();
    end
    rd(32'hC, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL b2b_end_status got %h want 00000002", d); else pass_cnt++;
    rd(32'h8, d);
    total_cnt++;
    if (d !== 32'hC3) $display("FAIL b2b_txdata got %h want 000000c3", d); else pass_cnt++;
  endtask

  initial begin
    bus.Addr = '0;
    bus.Din  = '0;
    bus.WE   = 1'b0;
    test_reset();
    test_frame_a5();
    test_done_clear();
    test_en_off();
    test_overrun();
    test_div0();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
